// File: rtl/vga_pkg.sv
// Shared VGA raster constants and the coordinate type used by sprite/bullet stages.
package vga_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus registered sync/visible flags derived
// from the next count so they stay aligned with the count register.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL      = H_TOTAL,
  parameter int unsigned SYNC_START = H_VISIBLE + H_FRONT,
  parameter int unsigned SYNC_WIDTH = H_SYNC,
  parameter int unsigned VISIBLE    = H_VISIBLE
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   advance,
  output coord_t count,
  output logic   sync_n,
  output logic   visible,
  output logic   wrap_c,
  output coord_t next_count_c
);

  localparam coord_t LAST    = COORD_W'(TOTAL - 1);
  localparam coord_t SYNC_LO = COORD_W'(SYNC_START);
  localparam coord_t SYNC_HI = COORD_W'(SYNC_START + SYNC_WIDTH);
  localparam coord_t VIS_LIM = COORD_W'(VISIBLE);

  function automatic logic in_sync(input coord_t c);
    return (c >= SYNC_LO) && (c < SYNC_HI);
  endfunction

  always_comb begin
    wrap_c       = (count == LAST);
    next_count_c = count;
    if (advance) begin
      next_count_c = wrap_c ? '0 : count + COORD_W'(1);
    end
  end

  // Flags are computed from the value the counter is about to take.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      sync_n  <= ~in_sync('0);
      visible <= (VIS_LIM != '0);
    end else begin
      count   <= next_count_c;
      sync_n  <= ~in_sync(next_count_c);
      visible <= (next_count_c < VIS_LIM);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel coordinates, syncs, blank and frame/line pulses,
// all cycle-aligned with the coordinate registers.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT   = vga_pkg::H_FRONT,
  parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK    = vga_pkg::H_BACK,
  parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT   = vga_pkg::V_FRONT,
  parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK    = vga_pkg::V_BACK
) (
  input  logic            vga_clk,
  input  logic            reset,
  output logic            hs,
  output logic            vs,
  output logic            blank,
  output vga_pkg::coord_t DrawX,
  output vga_pkg::coord_t DrawY,
  output logic            frame_start,
  output logic            line_end
);

  localparam int unsigned W       = vga_pkg::COORD_W;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam vga_pkg::coord_t H_LAST = W'(H_TOTAL - 1);

  vga_pkg::coord_t h_next;
  vga_pkg::coord_t v_next;
  logic            h_wrap;
  logic            v_wrap_unused;
  logic            h_vis;
  logic            v_vis;

  vga_axis_counter #(
    .TOTAL     (H_TOTAL),
    .SYNC_START(H_VISIBLE + H_FRONT),
    .SYNC_WIDTH(H_SYNC),
    .VISIBLE   (H_VISIBLE)
  ) u_h (
    .clk         (vga_clk),
    .reset       (reset),
    .advance     (1'b1),
    .count       (DrawX),
    .sync_n      (hs),
    .visible     (h_vis),
    .wrap_c      (h_wrap),
    .next_count_c(h_next)
  );

  // Vertical axis steps once per line, on the horizontal wrap.
  vga_axis_counter #(
    .TOTAL     (V_TOTAL),
    .SYNC_START(V_VISIBLE + V_FRONT),
    .SYNC_WIDTH(V_SYNC),
    .VISIBLE   (V_VISIBLE)
  ) u_v (
    .clk         (vga_clk),
    .reset       (reset),
    .advance     (h_wrap),
    .count       (DrawY),
    .sync_n      (vs),
    .visible     (v_vis),
    .wrap_c      (v_wrap_unused),
    .next_count_c(v_next)
  );

  assign blank = h_vis & v_vis;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      frame_start <= 1'b1;
      line_end    <= 1'b0;
    end else begin
      frame_start <= (h_next == '0) && (v_next == '0);
      line_end    <= (h_next == H_LAST);
    end
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing from the 25 MHz pixel clock. It drives the pixel coordinates and display-active flag consumed by every sprite renderer (`DrawX`, `DrawY`, `blank`), plus the sync pulses sent to the monitor. It sits directly upstream of all sprite/palette stages. Its outputs are a pure function of the registered counters, so sprite ROMs read on the falling edge see stable addresses.

## Interface
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `vga_clk` input 1 pixel clock, 25 MHz; all state on rising edge
- `reset` input 1 asynchronous, active-high; clears all state immediately
- `hs` output 1 horizontal sync, active-low
- `vs` output 1 vertical sync, active-low
- `blank` output 1 high = visible region (draw), low = blanking
- `DrawX` output 10 current horizontal count, 0..H_TOTAL-1
- `DrawY` output 10 current vertical count, 0..V_TOTAL-1
- `frame_start` output 1 one-cycle pulse at DrawX=0, DrawY=0
- `line_end` output 1 one-cycle pulse at DrawX=H_TOTAL-1

## Operation
- H_TOTAL = sum of the H parameters (800). V_TOTAL = sum of the V parameters (525). Both fit in 10 bits; parameter sets exceeding 1023 are illegal.
- Horizontal counter `hc`:
  - Increments every cycle.
  - At H_TOTAL-1 it wraps to 0 and a line advance occurs.
- Vertical counter `vc`:
  - Increments only on a line advance.
  - At V_TOTAL-1 with a line advance, it wraps to 0.
- `DrawX` = hc and `DrawY` = vc, driven directly from the registers with no extra delay.
- `hs` is low iff H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC, i.e. hc 656..751 by default.
- `vs` is low iff V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC, i.e. vc 490..491 by default.
- `blank` is high iff hc < H_VISIBLE and vc < V_VISIBLE.
- `frame_start` is high iff hc==0 and vc==0. `line_end` is high iff hc==H_TOTAL-1.
- `hs`, `vs`, `blank` and the pulses are registered, computed from next-state counter values. They are cycle-aligned with `DrawX`/`DrawY`: every output describes the same pixel in the same cycle.
- Reset values (asynchronous):
  - hc=0, vc=0
  - DrawX=0, DrawY=0
  - hs=1, vs=1
  - blank=1, since (0,0) is visible
  - frame_start=1
  - line_end=0
- Reset asserted mid-frame: all outputs take their reset values without waiting for a clock edge.
- Reset released: the first rising edge advances to hc=1, vc=0. The frame restarts cleanly with no partial sync pulse.
- Simultaneous horizontal and vertical wrap (hc=799, vc=524): the next cycle is hc=0, vc=0 with frame_start=1.

## Timing
- Latency from counter to every output is 0 cycles. All outputs change only on the `vga_clk` rising edge or on `reset`.
- Line period is 800 cycles. Frame period is 420000 cycles.
- hsync is low for 96 consecutive cycles per line. vsync is low for exactly 1600 consecutive cycles per frame, starting at hc=0 of line 490.
- `blank` is high for 640 consecutive cycles on each of lines 0..479, giving 307200 visible cycles per frame.
- Downstream sprite ROMs clocked on `~vga_clk` sample `DrawX`/`DrawY` half a cycle after they change. Their registered colour lands on the next rising edge, one pixel late. Downstream stages are responsible for compensating that lag.

## Structure
- Shared package `vga_pkg` holds:
  - default timing constants: H_VISIBLE, H_FRONT, H_SYNC, H_BACK, the V equivalents, H_TOTAL and V_TOTAL
  - typedef `coord_t` (logic [9:0]), reused by sprite and bullet modules for positions
- One natural sub-module, `vga_axis_counter`. It is instantiated twice (horizontal and vertical) and has:
  - parameters: total, sync start, sync width, visible
  - inputs: clock, reset, advance-enable
  - outputs: count, sync_n, visible, wrap, next-count
- The top level combines the two instances for `blank` and `frame_start`.

## Test plan
- Reset release, run 1600 cycles → DrawX counts 0..799 twice, DrawY goes 0→1 exactly at cycle 800, `line_end` pulses at cycles 799 and 1599.
- One full line → `hs` low exactly when DrawX=656..751 (96 cycles), high elsewhere; `blank` high for DrawX 0..639 on line 0.
- One full frame (420000 cycles) → `vs` low only for DrawY 490..491 (1600 cycles); `blank` high count = 307200; `frame_start` high at cycles 0 and 420000 only.
- Wrap corner: observe the cycle at DrawX=799, DrawY=524 → next cycle is DrawX=0, DrawY=0, `frame_start`=1, `hs`=1, `vs`=1, `blank`=1.
- Reset asserted asynchronously (between edges) at DrawX=300, DrawY=200 → outputs immediately DrawX=0, DrawY=0, `hs`=1, `vs`=1; after release, a full 420000-cycle frame repeats with correct checks.
- Bench check of sync polarity and alignment: on every cycle, `hs`, `vs` and `blank` equal the values recomputed from the same cycle's DrawX/DrawY; zero mismatches over 2 frames.
